// File: rtl/enc_pkt_arbiter_pkg.sv
// enc_arb_pkg: shared types and helpers for the encoder packet arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   MAX_NUM     : largest supported requester count
//   onehot2idx  : one-hot vector to binary index
package enc_arb_pkg;

   localparam int MAX_NUM = 8;
   localparam int MAX_IDX_W = $clog2(MAX_NUM);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_NUM-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_NUM; i++) begin
         if (oh[i]) idx = MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/enc_pkt_arbiter_if.sv
// enc_pkt_arbiter_if: bundle between the per-channel encoders / downstream
// framer (master side) and the packet arbiter (slave side).
//   i_req/i_valid/i_last/i_data : per-channel request and beat stream
//   i_ready                     : per-channel ready back to encoders
//   o_grant/o_busy              : registered grant vector and busy flag
//   o_valid/o_data/o_last       : muxed stream to the framer
//   o_ready                     : framer ready
interface enc_pkt_arbiter_if #(
   parameter int NUM        = 2,
   parameter int DATA_WIDTH = 32
);
   logic [NUM-1:0]            i_req;
   logic [NUM-1:0]            i_valid;
   logic [NUM-1:0]            i_last;
   logic [NUM*DATA_WIDTH-1:0] i_data;
   logic [NUM-1:0]            i_ready;
   logic [NUM-1:0]            o_grant;
   logic                      o_valid;
   logic [DATA_WIDTH-1:0]     o_data;
   logic                      o_last;
   logic                      o_ready;
   logic                      o_busy;

   modport master (
      output i_req, i_valid, i_last, i_data, o_ready,
      input  i_ready, o_grant, o_valid, o_data, o_last, o_busy
   );

   modport slave (
      input  i_req, i_valid, i_last, i_data, o_ready,
      output i_ready, o_grant, o_valid, o_data, o_last, o_busy
   );
endinterface

// File: rtl/enc_rr_pick.sv
// enc_rr_pick: combinational winner selection.
//   req      : per-channel request
//   last_idx : channel that held the previous grant
//   prio_en  : channel 0 gets anti-starving priority
//   winner   : one-hot winner, zero when nothing requests
module enc_rr_pick #(
   parameter int NUM  = 2,
   parameter int IDXW = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic [NUM-1:0]  req,
   input  logic [IDXW-1:0] last_idx,
   input  logic            prio_en,
   output logic [NUM-1:0]  winner
);

   logic            found;
   logic            others;
   logic [IDXW-1:0] cand;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      others = |(req >> 1);
      // Channel 0 wins unless it just had the grant and someone else waits,
      // so it can never lock out the other encoders.
      if (prio_en && req[0] && ((last_idx != '0) || !others)) begin
         winner[0] = 1'b1;
      end else begin
         for (int i = 1; i <= NUM; i++) begin
            cand = IDXW'((int'(last_idx) + i) % NUM);
            if (!found && req[cand]) begin
               winner[cand] = 1'b1;
               found        = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/enc_pkt_arbiter.sv
// enc_pkt_arbiter: packet-aware round-robin arbiter sharing one encoder
// output stream between NUM encoder channels. A grant is held until the
// packet's last beat, MAX_BURST beats, or an abort by the granted channel.
//   sys_clk : clock, rising edge
//   sys_rst : asynchronous active-high reset
//   bus     : enc_pkt_arbiter_if slave port (handshake + data)
//
//   state | meaning
//   IDLE  | no grant; choose a winner if anyone requests
//   GRANT | one channel owns the output stream
module enc_pkt_arbiter
   import enc_arb_pkg::*;
#(
   parameter int NUM        = 2,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16,
   parameter int PRIO_EN    = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   enc_pkt_arbiter_if.slave bus
);

   localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int CNTW = $clog2(MAX_BURST + 1);

   arb_state_e            state_q, state_d;
   logic [NUM-1:0]        grant_q, grant_d;
   logic                  busy_q, busy_d;
   logic [IDXW-1:0]       last_idx_q, last_idx_d;
   logic [CNTW-1:0]       beat_cnt_q, beat_cnt_d;

   logic [NUM-1:0]        winner;
   logic [DATA_WIDTH-1:0] data_g;
   logic                  valid_g;
   logic                  last_g;
   logic                  req_g;
   logic                  xfer;
   logic [CNTW-1:0]       cnt_inc;

   enc_rr_pick #(
      .NUM  (NUM),
      .IDXW (IDXW)
   ) u_pick (
      .req      (bus.i_req),
      .last_idx (last_idx_q),
      .prio_en  (PRIO_EN != 0),
      .winner   (winner)
   );

   // One-hot AND-OR mux; with no grant everything collapses to zero.
   always_comb begin
      data_g  = '0;
      valid_g = 1'b0;
      last_g  = 1'b0;
      req_g   = 1'b0;
      for (int k = 0; k < NUM; k++) begin
         if (grant_q[k]) begin
            data_g  = data_g | bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
            valid_g = valid_g | bus.i_valid[k];
            last_g  = last_g | bus.i_last[k];
            req_g   = req_g | bus.i_req[k];
         end
      end
   end

   assign xfer    = valid_g & bus.o_ready;
   assign cnt_inc = beat_cnt_q + CNTW'(1);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      busy_d     = busy_q;
      last_idx_d = last_idx_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (|bus.i_req) begin
               state_d    = GRANT;
               grant_d    = winner;
               busy_d     = 1'b1;
               beat_cnt_d = '0;
               last_idx_d = IDXW'(onehot2idx(MAX_NUM'(winner)));
            end
         end
         GRANT: begin
            if (xfer) beat_cnt_d = cnt_inc;
            // Releasing always passes through IDLE, which gives the
            // mandatory bubble between grants.
            if ((xfer && (last_g || (cnt_inc == CNTW'(MAX_BURST)))) ||
                (!req_g && !valid_g)) begin
               state_d = IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         busy_q     <= 1'b0;
         last_idx_q <= IDXW'(NUM - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         last_idx_q <= last_idx_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign bus.o_grant = grant_q;
   assign bus.o_busy  = busy_q;
   assign bus.o_valid = valid_g;
   assign bus.o_data  = data_g;
   assign bus.o_last  = last_g;
   assign bus.i_ready = grant_q & {NUM{bus.o_ready}};

endmodule
